// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: receives start/payload/parity/stop frames one bit
// per clock, checks stop and even parity, and hands good payloads to a
// one-entry valid/ready buffer. Error and overrun conditions are reported as
// single-cycle pulses in the cycle after the stop bit is sampled.
module serial_frame_deserializer #(
   parameter int DATA_WIDTH = 8,
   parameter int PARITY_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  serial_in,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic                  parity_bit_r;
   logic                  eval_s;
   logic                  stop_bad_s;
   logic                  par_bad_s;
   logic                  good_s;
   logic                  drain_s;

   // Even parity over payload plus parity bit: a non-zero result is a mismatch.
   function automatic logic parity_mismatch(input logic [DATA_WIDTH-1:0] data,
                                            input logic                  pbit);
      return ^{data, pbit};
   endfunction

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode and stop-edge frame evaluation.
   always_comb begin
      state_next_s = state_r;
      eval_s       = 1'b0;
      stop_bad_s   = 1'b0;
      par_bad_s    = 1'b0;
      good_s       = 1'b0;
      drain_s      = out_valid & out_ready;
      case (state_r)
         ST_IDLE: begin
            if (serial_in) begin
               state_next_s = ST_DATA;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (cnt_r == LAST_IDX) begin
               if (PARITY_EN != 0) begin
                  state_next_s = ST_PARITY;
               end else begin
                  state_next_s = ST_STOP;
               end
            end else begin
               state_next_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            state_next_s = ST_STOP;
         end
         ST_STOP: begin
            state_next_s = ST_IDLE;
            eval_s       = 1'b1;
            stop_bad_s   = serial_in;
            if (PARITY_EN != 0) begin
               par_bad_s = parity_mismatch(shift_r, parity_bit_r);
            end else begin
               par_bad_s = 1'b0;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      good_s = eval_s & ~stop_bad_s & ~par_bad_s;
   end

   // Bit counter, payload shift register and captured parity bit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_r        <= '0;
         shift_r      <= '0;
         parity_bit_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= '0;
            end
            ST_DATA: begin
               shift_r[cnt_r] <= serial_in;
               cnt_r          <= cnt_r + CNT_W'(1);
            end
            ST_PARITY: begin
               parity_bit_r <= serial_in;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Registered outputs: one-entry buffer, status pulses and busy flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_err  <= eval_s & stop_bad_s;
         parity_err <= eval_s & par_bad_s & ~stop_bad_s;
         overrun    <= good_s & out_valid & ~out_ready;
         busy       <= (state_next_s != ST_IDLE);
         // A drain and a reload on the same edge leave the buffer full.
         if (good_s && (!out_valid || out_ready)) begin
            out_data  <= shift_r;
            out_valid <= 1'b1;
         end else if (drain_s) begin
            out_valid <= 1'b0;
         end else begin
            out_valid <= out_valid;
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer (DATA_WIDTH=8, PARITY_EN=1).
// A frame-level reference model predicts the buffer state and status pulses
// after every clock edge; all outputs are compared each cycle.
module tb_serial_frame_deserializer;

   localparam int DW = 8;

   localparam int K_NONE  = 0;
   localparam int K_START = 1;
   localparam int K_STOP  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          serial_in;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          parity_err;
   logic          frame_err;
   logic          overrun;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_perr;
   logic          m_ferr;
   logic          m_ovr;
   logic          m_busy;
   logic [DW-1:0] cur_d;
   logic          cur_p;

   serial_frame_deserializer #(.DATA_WIDTH(DW), .PARITY_EN(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .serial_in  (serial_in),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_data",   out_data, m_data);
      chk("out_valid",  {7'd0, out_valid},  {7'd0, m_valid});
      chk("parity_err", {7'd0, parity_err}, {7'd0, m_perr});
      chk("frame_err",  {7'd0, frame_err},  {7'd0, m_ferr});
      chk("overrun",    {7'd0, overrun},    {7'd0, m_ovr});
      chk("busy",       {7'd0, busy},       {7'd0, m_busy});
   endtask

   // Apply one clock edge to the model; kind marks the start and stop bits.
   task automatic model_edge(input logic rdy, input int kind, input logic bit_v);
      logic consumed;
      logic good;
      if (!rst) begin
         m_data = '0; m_valid = 1'b0; m_perr = 1'b0;
         m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      end else begin
         consumed = m_valid && rdy;
         good     = 1'b0;
         m_perr   = 1'b0;
         m_ferr   = 1'b0;
         m_ovr    = 1'b0;
         if (kind == K_START) m_busy = 1'b1;
         if (kind == K_STOP) begin
            m_busy = 1'b0;
            if (bit_v) m_ferr = 1'b1;
            else if ((($countones(cur_d) + int'(cur_p)) % 2) != 0) m_perr = 1'b1;
            else good = 1'b1;
         end
         if (good) begin
            if (!m_valid || consumed) begin
               m_data  = cur_d;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (consumed) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic step(input logic s, input logic rdy, input int kind);
      serial_in = s;
      out_ready = rdy;
      @(posedge clk);
      model_edge(rdy, kind, s);
      #1;
      check_all();
   endtask

   // mode: 0 ready low, 1 ready high, 2 random ready, 3 ready only on the stop bit
   task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int mode);
      logic r;
      cur_d = d;
      cur_p = p;
      for (int i = 0; i < DW + 3; i++) begin
         case (mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            2:       r = 1'($urandom_range(0, 1));
            default: r = (i == DW + 2);
         endcase
         if (i == 0)           step(1'b1, r, K_START);
         else if (i <= DW)     step(d[i-1], r, K_NONE);
         else if (i == DW + 1) step(p, r, K_NONE);
         else                  step(s, r, K_STOP);
      end
   endtask

   initial begin
      logic [DW-1:0] d;
      logic          p;
      logic          s;
      rst       = 1'b0;
      serial_in = 1'b0;
      out_ready = 1'b0;
      m_data = '0; m_valid = 1'b0; m_perr = 1'b0;
      m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
      cur_d = '0; cur_p = 1'b0;

      // Reset, then idle line
      step(1'b0, 1'b0, K_NONE);
      step(1'b0, 1'b0, K_NONE);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, K_NONE);

      // Good frame 0xA5 with ready held high
      send_frame(8'hA5, 1'b0, 1'b0, 1);
      step(1'b0, 1'b1, K_NONE);
      step(1'b0, 1'b1, K_NONE);

      // Parity error, then stop-bit error
      send_frame(8'hA5, 1'b1, 1'b0, 1);
      step(1'b0, 1'b1, K_NONE);
      send_frame(8'hA5, 1'b0, 1'b1, 1);
      step(1'b0, 1'b1, K_NONE);

      // Back-to-back with consumer stalled: second frame overruns
      send_frame(8'hA5, 1'b0, 1'b0, 0);
      send_frame(8'h3C, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, K_NONE);
      step(1'b0, 1'b1, K_NONE);
      step(1'b0, 1'b1, K_NONE);

      // Drain and reload on the same edge
      send_frame(8'h11, 1'b0, 1'b0, 0);
      step(1'b0, 1'b0, K_NONE);
      send_frame(8'h22, 1'b0, 1'b0, 3);
      step(1'b0, 1'b1, K_NONE);

      // Reset in the middle of a frame, then a fresh frame
      step(1'b1, 1'b0, K_START);
      for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0, K_NONE);
      rst = 1'b0;
      step(1'b0, 1'b0, K_NONE);
      rst = 1'b1;
      step(1'b0, 1'b0, K_NONE);
      send_frame(8'h5A, 1'b0, 1'b0, 1);
      step(1'b0, 1'b1, K_NONE);

      // Randomized frames: random payload, occasional corruption, random gaps
      for (int f = 0; f < 40; f++) begin
         d = 8'($urandom);
         p = (^d) ^ ($urandom_range(0, 5) == 0);
         s = ($urandom_range(0, 7) == 0);
         send_frame(d, p, s, int'($urandom_range(0, 3)));
         for (int g = int'($urandom_range(0, 2)); g > 0; g--)
            step(1'b0, 1'($urandom_range(0, 1)), K_NONE);
      end
      step(1'b0, 1'b1, K_NONE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
